// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin arbiter that shares the single external IO bus
// among NUM_MASTERS requesters, with one transaction outstanding at a time.
// Optional slave-ack timeout is compiled in with `define IOBUS_ARB_TIMEOUT_EN.
module iobus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      i_m_re,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [4*NUM_MASTERS-1:0]    i_m_sel,
    input  logic [32*NUM_MASTERS-1:0]   i_m_addr,
    input  logic [32*NUM_MASTERS-1:0]   i_m_wdata,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [31:0]                 o_m_rdata,
    output logic [NUM_MASTERS-1:0]      o_grant,
    output logic                        o_s_re,
    output logic                        o_s_we,
    output logic [3:0]                  o_s_sel,
    output logic [31:0]                 o_s_addr,
    output logic [31:0]                 o_s_wdata,
    input  logic                        i_s_ack,
    input  logic [31:0]                 i_s_rdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [IDX_W-1:0]         ptr, ptr_d;
    logic [IDX_W-1:0]         gnt_idx, gnt_idx_d;
    logic [NUM_MASTERS-1:0]   o_m_ack_d, o_m_err_d, o_grant_d;
    logic [31:0]              o_m_rdata_d, o_s_addr_d, o_s_wdata_d;
    logic [3:0]               o_s_sel_d;
    logic                     o_s_re_d, o_s_we_d;
    logic                     found;
    logic [IDX_W-1:0]         sel_idx;
    int                       cand;
    logic                     timeout_hit;

`ifdef IOBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt, busy_cnt_d;
    assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES > 0);
    assign timeout_hit = 1'b0;
`endif

    // Round-robin scan: first requester at or above the pointer, with wrap.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        found   = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && (i_m_re[cand] || i_m_we[cand])) begin
                found   = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    // Next-state and next-output logic; registers hold unless a state acts.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        gnt_idx_d   = gnt_idx;
        o_grant_d   = o_grant;
        o_s_re_d    = o_s_re;
        o_s_we_d    = o_s_we;
        o_s_sel_d   = o_s_sel;
        o_s_addr_d  = o_s_addr;
        o_s_wdata_d = o_s_wdata;
        o_m_rdata_d = o_m_rdata;
        o_m_ack_d   = '0;
        o_m_err_d   = '0;
`ifdef IOBUS_ARB_TIMEOUT_EN
        busy_cnt_d  = busy_cnt;
`endif
        case (state)
            IDLE: begin
                o_grant_d = '0;
                if (found) begin
                    gnt_idx_d   = sel_idx;
                    o_grant_d   = NUM_MASTERS'(1) << sel_idx;
                    // re together with we is treated as a write
                    o_s_we_d    = i_m_we[sel_idx];
                    o_s_re_d    = i_m_re[sel_idx] && !i_m_we[sel_idx];
                    o_s_sel_d   = i_m_sel[sel_idx*4 +: 4];
                    o_s_addr_d  = i_m_addr[sel_idx*32 +: 32];
                    o_s_wdata_d = i_m_wdata[sel_idx*32 +: 32];
                    state_d     = BUSY;
`ifdef IOBUS_ARB_TIMEOUT_EN
                    busy_cnt_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (i_s_ack) begin
                    // a real ack wins over a timeout in the same cycle
                    o_s_re_d    = 1'b0;
                    o_s_we_d    = 1'b0;
                    o_m_rdata_d = o_s_re ? i_s_rdata : 32'h0;
                    o_m_ack_d   = NUM_MASTERS'(1) << gnt_idx;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    o_s_re_d    = 1'b0;
                    o_s_we_d    = 1'b0;
                    o_m_rdata_d = 32'hDEAD_BEEF;
                    o_m_ack_d   = NUM_MASTERS'(1) << gnt_idx;
                    o_m_err_d   = NUM_MASTERS'(1) << gnt_idx;
                    state_d     = RESP;
                end else begin
`ifdef IOBUS_ARB_TIMEOUT_EN
                    busy_cnt_d  = busy_cnt + 1'b1;
`endif
                end
            end
            RESP: begin
                o_grant_d = '0;
                ptr_d     = (int'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
                state_d   = IDLE;
            end
            default: begin
                o_grant_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            o_grant   <= '0;
            o_s_re    <= 1'b0;
            o_s_we    <= 1'b0;
            o_s_sel   <= '0;
            o_s_addr  <= '0;
            o_s_wdata <= '0;
            o_m_rdata <= '0;
            o_m_ack   <= '0;
            o_m_err   <= '0;
`ifdef IOBUS_ARB_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gnt_idx   <= gnt_idx_d;
            o_grant   <= o_grant_d;
            o_s_re    <= o_s_re_d;
            o_s_we    <= o_s_we_d;
            o_s_sel   <= o_s_sel_d;
            o_s_addr  <= o_s_addr_d;
            o_s_wdata <= o_s_wdata_d;
            o_m_rdata <= o_m_rdata_d;
            o_m_ack   <= o_m_ack_d;
            o_m_err   <= o_m_err_d;
`ifdef IOBUS_ARB_TIMEOUT_EN
            busy_cnt  <= busy_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Directed testbench for iobus_arbiter (two masters). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_iobus_arbiter;

    localparam int N = 2;
`ifdef IOBUS_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_re, m_we;
    logic [4*N-1:0]    m_sel;
    logic [32*N-1:0]   m_addr, m_wdata;
    logic [N-1:0]      m_ack, m_err, grant;
    logic [31:0]       m_rdata;
    logic              s_re, s_we;
    logic [3:0]        s_sel;
    logic [31:0]       s_addr, s_wdata;
    logic              s_ack;
    logic [31:0]       s_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int acks [N];

    iobus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_m_re(m_re), .i_m_we(m_we), .i_m_sel(m_sel),
        .i_m_addr(m_addr), .i_m_wdata(m_wdata),
        .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rdata(m_rdata),
        .o_grant(grant),
        .o_s_re(s_re), .o_s_we(s_we), .o_s_sel(s_sel),
        .o_s_addr(s_addr), .o_s_wdata(s_wdata),
        .i_s_ack(s_ack), .i_s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int m, input logic re, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
        m_re[m]             = re;
        m_we[m]             = we;
        m_sel[m*4 +: 4]     = sel;
        m_addr[m*32 +: 32]  = addr;
        m_wdata[m*32 +: 32] = wdata;
    endtask

    task automatic clr_req(input int m);
        set_req(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_re = '0; m_we = '0; m_sel = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        acks[0] = 0; acks[1] = 0;
        tick();
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_re", 32'(s_re), 32'h0);
        check("rst_s_we", 32'(s_we), 32'h0);
        check("rst_ack", 32'(m_ack), 32'h0);
        check("rst_err", 32'(m_err), 32'h0);
        check("rst_rdata", m_rdata, 32'h0);
        check("rst_addr", s_addr, 32'h0);

        // Single write from m0; slave acks 2 cycles after the strobe
        set_req(0, 1'b0, 1'b1, 4'hF, 32'h0001_0000, 32'd34);
        tick();
        check("wr_s_we", 32'(s_we), 32'h1);
        check("wr_s_re", 32'(s_re), 32'h0);
        check("wr_addr", s_addr, 32'h0001_0000);
        check("wr_wdata", s_wdata, 32'd34);
        check("wr_sel", 32'(s_sel), 32'hF);
        check("wr_grant", 32'(grant), 32'h1);
        tick();
        check("wr_hold_we", 32'(s_we), 32'h1);
        check("wr_no_ack_yet", 32'(m_ack), 32'h0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        check("wr_ack", 32'(m_ack), 32'h1);
        check("wr_err", 32'(m_err), 32'h0);
        check("wr_resp_grant", 32'(grant), 32'h1);
        check("wr_strobe_drop", 32'(s_we), 32'h0);
        check("wr_rdata", m_rdata, 32'h0);
        clr_req(0);
        tick();
        check("wr_idle_grant", 32'(grant), 32'h0);
        check("wr_ack_one_cycle", 32'(m_ack), 32'h0);

        // Single read from m1
        set_req(1, 1'b1, 1'b0, 4'hF, 32'h0001_0004, 32'h0);
        tick();
        check("rd_grant", 32'(grant), 32'h2);
        check("rd_s_re", 32'(s_re), 32'h1);
        check("rd_s_we", 32'(s_we), 32'h0);
        check("rd_addr", s_addr, 32'h0001_0004);
        tick();
        s_ack = 1'b1; s_rdata = 32'h1234_5678;
        tick();
        s_ack = 1'b0; s_rdata = 32'h0;
        check("rd_ack", 32'(m_ack), 32'h2);
        check("rd_rdata", m_rdata, 32'h1234_5678);
        clr_req(1);
        tick();

        // Contention: both masters request continuously from reset
        rst = 1'b1;
        set_req(0, 1'b0, 1'b1, 4'h3, 32'h0000_0100, 32'hAAAA_0000);
        set_req(1, 1'b1, 1'b0, 4'hC, 32'h0000_0200, 32'h0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("cont_grant_%0d", t), 32'(grant), 32'(1 << (t % 2)));
            check($sformatf("cont_addr_%0d", t), s_addr, (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            s_ack = 1'b1; s_rdata = 32'h5555_0000 + 32'(t);
            tick();
            s_ack = 1'b0;
            check($sformatf("cont_ack_%0d", t), 32'(m_ack), 32'(1 << (t % 2)));
            check($sformatf("cont_rdata_%0d", t), m_rdata, (t % 2 == 0) ? 32'h0 : 32'h5555_0000 + 32'(t));
            for (int k = 0; k < N; k++) if (m_ack[k]) acks[k]++;
            tick();
            check($sformatf("cont_gap_%0d", t), 32'(grant), 32'h0);
        end
        check("cont_acks_m0", 32'(acks[0]), 32'd2);
        check("cont_acks_m1", 32'(acks[1]), 32'd2);
        clr_req(0); clr_req(1);
        do_reset();

        // Same-cycle ack: request cycle 0 -> ack in cycle 2
        set_req(0, 1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h0000_0077);
        tick();
        check("fast_s_we", 32'(s_we), 32'h1);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        check("fast_ack", 32'(m_ack), 32'h1);
        clr_req(0);
        tick();
        // New transaction, then reset while BUSY
        set_req(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        tick();
        check("abort_busy_grant", 32'(grant), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_req(1);
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_s_re", 32'(s_re), 32'h0);
        check("abort_addr", s_addr, 32'h0);
        check("abort_ack", 32'(m_ack), 32'h0);
        s_ack = 1'b1; s_rdata = 32'hCAFE_F00D;
        tick();
        s_ack = 1'b0; s_rdata = 32'h0;
        check("late_ack_ign", 32'(m_ack), 32'h0);
        tick();
        check("late_ack_ign2", 32'(m_ack), 32'h0);
        check("late_ack_rdata", m_rdata, 32'h0);

        // Pointer restarts at 0 after reset: both request, m0 wins
        set_req(0, 1'b1, 1'b1, 4'h1, 32'h0000_0030, 32'h0000_00BB);
        set_req(1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        s_rdata = 32'hFFFF_FFFF;
        tick();
        check("rw_grant", 32'(grant), 32'h1);
        check("rw_s_we", 32'(s_we), 32'h1);
        check("rw_s_re", 32'(s_re), 32'h0);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; s_rdata = 32'h0;
        check("rw_ack", 32'(m_ack), 32'h1);
        check("rw_rdata", m_rdata, 32'h0);
        clr_req(0); clr_req(1);
        tick();
        do_reset();

`ifdef IOBUS_ARB_TIMEOUT_EN
        // Timeout: m0 read never acked, m1 pending
        set_req(0, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("to_wait_%0d", c), 32'(m_ack), 32'h0);
        end
        tick();
        check("to_ack", 32'(m_ack), 32'h1);
        check("to_err", 32'(m_err), 32'h1);
        check("to_rdata", m_rdata, 32'hDEAD_BEEF);
        check("to_s_re", 32'(s_re), 32'h0);
        clr_req(0);
        tick();
        tick();
        check("to_next_grant", 32'(grant), 32'h2);
        s_ack = 1'b1; s_rdata = 32'h0000_0042;
        tick();
        s_ack = 1'b0;
        check("to_next_ack", 32'(m_ack), 32'h2);
        check("to_next_err", 32'(m_err), 32'h0);
        clr_req(1);
        tick();
`else
        // No timeout: BUSY waits indefinitely, error output stays low
        set_req(0, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            check($sformatf("nto_wait_%0d", c), 32'({m_ack, m_err}), 32'h0);
        end
        check("nto_still_re", 32'(s_re), 32'h1);
        s_ack = 1'b1; s_rdata = 32'h0000_0099;
        tick();
        s_ack = 1'b0;
        check("nto_ack", 32'(m_ack), 32'h1);
        check("nto_err", 32'(m_err), 32'h0);
        check("nto_rdata", m_rdata, 32'h0000_0099);
        clr_req(0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
